bp_be_issue_queue_nw: RTL
=========================

Name: bp_be_issue_queue_nw

Overview:
- Parametrised N-wide successor to the dual-issue BE issue queue. Circular buffer between the FE queue and the BE scheduler.
- Accepts up to width_p fetch packets per cycle and presents up to width_p oldest unread packets per cycle.
- Keeps issued-but-uncommitted entries so the checker can roll back to the commit point, or clear speculative entries.
- Replaces the fixed 2-wide pointer-step scheme with count-based pointer advance for any width_p and depth.

Parameters:
- width_p, 2, lanes per cycle for enqueue, read and commit.
- els_p, 16, queue depth; power of two, at least 2*width_p.
- data_width_p, 64, payload bits per entry (fe_queue packet width).

Ports:
- clk_i  in  1  clock.
- reset_n_i  in  1  reset; asynchronous, active-low.
- clr_v_i  in  1  director clear; discard all unread entries.
- roll_v_i  in  1  commit roll; rewind read pointer to the commit point.
- deq_cnt_i  in  clog2(width_p+1)  entries committed this cycle.
- enq_v_i  in  width_p  per-lane enqueue valid.
- enq_data_i  in  width_p*data_width_p  enqueue payloads; lane k at bits [k*data_width_p +: data_width_p].
- enq_ready_o  out  1  queue can accept width_p entries.
- deq_v_o  out  width_p  per-lane read-window valid.
- deq_data_o  out  width_p*data_width_p  read-window payloads.
- yumi_cnt_i  in  clog2(width_p+1)  entries consumed from the read window.
- unread_cnt_o  out  clog2(els_p+1)  wptr - rptr.
- inflight_cnt_o  out  clog2(els_p+1)  rptr - cptr.

Behaviour:
- Pointers:
  - wptr, rptr and cptr are each clog2(els_p)+1 bits: index plus wrap bit. All reset to 0.
  - Storage index is ptr mod els_p.
  - All pointer arithmetic is modulo 2*els_p.
- Occupancy: wptr - cptr; full when it equals els_p.
- Reset:
  - reset_n_i low clears all pointers immediately, without waiting for a clock edge.
  - Outputs during and after reset: deq_v_o=0, deq_data_o=0, unread_cnt_o=0, inflight_cnt_o=0, enq_ready_o=~clr_v_i.
  - Storage array is not reset.
- Enqueue:
  - enq_ready_o = ~clr_v_i & (els_p - occupancy >= width_p). Combinational from registered pointers.
  - Accepted count n = number of consecutive 1s in enq_v_i starting at lane 0, only when enq_ready_o=1; otherwise n=0.
  - Lanes above the first 0 are ignored.
  - Lane k is written at wptr+k; wptr_n = wptr + n.
- Read window:
  - deq_v_o[k] = ~roll_v_i & (k < unread_cnt).
  - deq_data_o lane k = mem[rptr+k] when deq_v_o[k], else 0. Combinational read.
  - An entry written this cycle becomes visible the next cycle; there is no same-cycle bypass.
  - rptr_n = rptr + yumi_cnt_i.
  - yumi_cnt_i must not exceed popcount(deq_v_o). Violation is a simulation assertion.
- Commit:
  - cptr_n = cptr + deq_cnt_i.
  - deq_cnt_i must not exceed inflight_cnt_o. Violation is an assertion.
- Roll:
  - roll_v_i=1 forces rptr_n = cptr_n, i.e. cptr + deq_cnt_i.
  - yumi_cnt_i is ignored during a roll.
- Clear:
  - clr_v_i=1 forces wptr_n = rptr_n, taken after read/roll resolution.
  - Enqueue is blocked while clr_v_i=1.
- Simultaneous roll and clear: wptr_n = rptr_n = cptr_n; the queue is empty the next cycle.
- Wrap-around:
  - A lane index that crosses els_p-1 continues at 0.
  - Full/empty are distinguished by the wrap bit, so there is no false full or false empty.

Test Plan (width_p=2, els_p=8):
1. Fill:
   - Stimulus: from reset, enq_v_i=2'b11 for 4 cycles, no yumi.
   - Response: after cycle 3, unread=6 and enq_ready_o=1; after cycle 4, unread=8 and enq_ready_o=0; a fifth enqueue is not accepted.
2. Partial/gapped lanes:
   - enq_v_i=2'b10 -> nothing accepted, unread=0.
   - Then enq_v_i=2'b01 with data 0xA -> next cycle unread=1, deq_v_o=2'b01, lane0=0xA, lane1=0.
3. Roll:
   - Enqueue A,B,C,D, then yumi_cnt=2 -> inflight=2, unread=2.
   - Next cycle roll_v_i=1, deq_cnt_i=1, yumi_cnt_i=2 -> deq_v_o=0 that cycle.
   - Following cycle: inflight=0, unread=3, lane0=B, lane1=C.
4. Clear:
   - With unread=3, inflight=0: clr_v_i=1, yumi_cnt_i=1, enq_v_i=2'b11 -> enq_ready_o=0.
   - Next cycle: unread=0, inflight=1; the enqueue is discarded.
5. Wrap:
   - Stream 20 sequential values at 2 per cycle, with yumi and deq_cnt each 2 per cycle.
   - deq_data_o order is exactly 0..19 across index 7->0, with no stall and enq_ready_o=1 throughout.
6. Async reset:
   - With unread=5, drop reset_n_i between clock edges.
   - Counts go to 0, deq_v_o=0 and enq_ready_o=1 before the next edge.
   - After release, the first enqueue lands at index 0.

Source files
------------

// File: rtl/bp_be_issue_queue_nw.sv
// N-wide backend issue queue: circular buffer between the FE queue and the
// BE scheduler. Three pointers (write, read, commit) carry an extra wrap bit
// so full and empty are told apart without a separate flag. Entries between
// the commit and read pointers are kept so the checker can roll back.
module bp_be_issue_queue_nw #(
    parameter int width_p      = 2,
    parameter int els_p        = 16,
    parameter int data_width_p = 64
) (
    input  logic                              clk_i,
    input  logic                              reset_n_i,
    input  logic                              clr_v_i,
    input  logic                              roll_v_i,
    input  logic [$clog2(width_p+1)-1:0]      deq_cnt_i,
    input  logic [width_p-1:0]                enq_v_i,
    input  logic [width_p*data_width_p-1:0]   enq_data_i,
    output logic                              enq_ready_o,
    output logic [width_p-1:0]                deq_v_o,
    output logic [width_p*data_width_p-1:0]   deq_data_o,
    input  logic [$clog2(width_p+1)-1:0]      yumi_cnt_i,
    output logic [$clog2(els_p+1)-1:0]        unread_cnt_o,
    output logic [$clog2(els_p+1)-1:0]        inflight_cnt_o
);

    localparam int idx_w = $clog2(els_p);
    localparam int ptr_w = idx_w + 1;
    localparam int cnt_w = $clog2(width_p + 1);

    typedef logic [ptr_w-1:0] ptr_t;
    typedef logic [cnt_w-1:0] lane_cnt_t;

    ptr_t      wptr_r, rptr_r, cptr_r;
    ptr_t      wptr_n, rptr_n, cptr_n;
    ptr_t      unread, inflight, occupancy;
    lane_cnt_t enq_cnt;
    logic      enq_run;

    logic [data_width_p-1:0] mem [els_p];

    // Storage slot of a pointer: drop the wrap bit.
    function automatic logic [idx_w-1:0] slot(input ptr_t p);
        return p[idx_w-1:0];
    endfunction

    // Wrap-bit subtraction yields exact counts even across index wrap.
    assign unread         = wptr_r - rptr_r;
    assign inflight       = rptr_r - cptr_r;
    assign occupancy      = wptr_r - cptr_r;
    assign unread_cnt_o   = unread;
    assign inflight_cnt_o = inflight;
    assign enq_ready_o    = ~clr_v_i & ((ptr_t'(els_p) - occupancy) >= ptr_t'(width_p));

    // Accepted lanes: the unbroken run of valids starting at lane 0.
    always_comb begin
        // NOTE: every variable gets a default before any conditional update so no latch is inferred.
        enq_cnt = '0;
        enq_run = enq_ready_o;
        for (int k = 0; k < width_p; k++) begin
            if (enq_run && enq_v_i[k]) begin
                enq_cnt = enq_cnt + lane_cnt_t'(1);
            end else begin
                enq_run = 1'b0;
            end
        end
    end

    // Read window: oldest unread entries, suppressed entirely during a roll.
    always_comb begin
        deq_v_o    = '0;
        deq_data_o = '0;
        for (int k = 0; k < width_p; k++) begin
            if (!roll_v_i && (ptr_t'(k) < unread)) begin
                deq_v_o[k] = 1'b1;
                deq_data_o[k*data_width_p +: data_width_p] = mem[slot(rptr_r + ptr_t'(k))];
            end
        end
    end

    // Next pointers: commit first, roll overrides read, clear overrides write.
    always_comb begin
        cptr_n = cptr_r + ptr_t'(deq_cnt_i);
        rptr_n = roll_v_i ? cptr_n : rptr_r + ptr_t'(yumi_cnt_i);
        wptr_n = clr_v_i  ? rptr_n : wptr_r + ptr_t'(enq_cnt);
    end

    // Pointer registers with asynchronous clear.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
        if (!reset_n_i) begin
            wptr_r <= '0;
            rptr_r <= '0;
            cptr_r <= '0;
        end else begin
            wptr_r <= wptr_n;
            rptr_r <= rptr_n;
            cptr_r <= cptr_n;
        end
    end

    // Payload storage write for each accepted lane.
    always_ff @(posedge clk_i) begin
        // NOTE: the array has no reset; slots are only read once the pointers mark them as written.
        for (int k = 0; k < width_p; k++) begin
            if (lane_cnt_t'(k) < enq_cnt) begin
                mem[slot(wptr_r + ptr_t'(k))] <= enq_data_i[k*data_width_p +: data_width_p];
            end
        end
    end

    // Consumer protocol checks.
    yumi_within_window: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        !roll_v_i |-> (int'(yumi_cnt_i) <= $countones(deq_v_o)));

    commit_within_inflight: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        int'(deq_cnt_i) <= int'(inflight));

endmodule
